// File: rtl/mul16_seq.sv
// Shift-add 16x16 unsigned multiplier that drives the shared ripple adder.
// Optional MUL16_ZERO_SKIP_EN: zero operands finish in one cycle.
module mul16_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_cout,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lo;
    logic [4:0]       cnt;

    // Adder operands are only driven while running; zero otherwise.
    assign add_a   = (state == RUN) ? acc : '0;
    assign add_b   = (state == RUN && lo[0]) ? mcand : '0;
    assign add_cin = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            lo      <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
`ifdef MUL16_ZERO_SKIP_EN
                        if (a == '0 || b == '0) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            product <= '0;
                            mcand   <= '0;
                            acc     <= '0;
                            lo      <= '0;
                            cnt     <= '0;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            mcand <= a;
                            lo    <= b;
                            acc   <= '0;
                            cnt   <= '0;
                        end
`else
                        state <= RUN;
                        busy  <= 1'b1;
                        mcand <= a;
                        lo    <= b;
                        acc   <= '0;
                        cnt   <= '0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // 33-bit right shift of {cout, sum, lo}
                    {acc, lo} <= {add_cout, add_sum, lo[WIDTH-1:1]};
                    cnt       <= cnt + 5'd1;
                    if (cnt == 5'(WIDTH - 1)) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= {add_cout, add_sum, lo[WIDTH-1:1]};
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul16_seq.sv
// Testbench for mul16_seq: vector table plus handshake corner sequences.
// Honours MUL16_ZERO_SKIP_EN when computing expected latency.
module tb_mul16_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int nb = 0;
    logic [31:0] sb[$];

    mul16_seq #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .busy     (busy),
        .done     (done),
        .product  (product)
    );

    // Shared ripple adder model
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (busy) nb++;
        else chk("idle_adder_ops", {add_a, add_b}, 32'h0);
        chk("cin_zero", {31'b0, add_cin}, 32'h0);
    end

    function automatic int elat(input logic [15:0] x, input logic [15:0] y);
`ifdef MUL16_ZERO_SKIP_EN
        if (x == 16'h0 || y == 16'h0) return 1;
`endif
        return 17;
    endfunction

    function automatic int ebusy(input logic [15:0] x, input logic [15:0] y);
`ifdef MUL16_ZERO_SKIP_EN
        if (x == 16'h0 || y == 16'h0) return 0;
`endif
        return 16;
    endfunction

    task automatic launch(input logic [15:0] x, input logic [15:0] y, input logic [31:0] p);
        start = 1'b1;
        a = x;
        b = y;
        sb.push_back(p);
        t0 = cyc;
        nb = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic await_done(input int el, input int eb);
        logic [31:0] exp;
        while (!done && (cyc - t0) < 60) @(negedge clk);
        chk("latency", cyc - t0, el);
        chk("busy_cycles", nb, eb);
        chk("busy_at_done", {31'b0, busy}, 32'h0);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 32'h0, 32'h1);
        end else begin
            exp = sb.pop_front();
            chk("product", product, exp);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs[7];
    int tf;

    initial begin
        vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{16'h0000, 16'h00FF, 32'h00000000};
        vecs[3] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
        vecs[4] = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[5] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
        vecs[6] = '{16'hABCD, 16'h0000, 32'h00000000};

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_product", product, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].p);
            await_done(elat(vecs[i].a, vecs[i].b), ebusy(vecs[i].a, vecs[i].b));
            @(negedge clk);
            chk("done_one_cycle", {31'b0, done}, 32'h0);
        end

        // Start during RUN must be ignored
        launch(16'h1234, 16'h5678, 32'h06260060);
        repeat (4) @(negedge clk);
        start = 1'b1;
        a = 16'h0001;
        b = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        await_done(17, 16);
        @(negedge clk);
        chk("no_queued_start", {31'b0, busy}, 32'h0);
        repeat (2) @(negedge clk);
        chk("no_queued_done", {31'b0, done}, 32'h0);

        // Reset mid-operation
        launch(16'h0007, 16'h0009, 32'd63);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_product", product, 32'h0);
        chk("rst_adder", {add_a, add_b}, 32'h0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", {31'b0, done}, 32'h0);
        end
        launch(16'h0002, 16'h0002, 32'd4);
        await_done(17, 16);
        @(negedge clk);

        // Back-to-back through the DONE cycle
        launch(16'h0002, 16'h0003, 32'd6);
        await_done(17, 16);
        tf = t0;
        launch(16'h000A, 16'h000A, 32'd100);
        chk("b2b_busy", {31'b0, busy}, 32'h1);
        while (!done && (cyc - t0) < 60) begin
            chk("b2b_held", product, 32'd6);
            @(negedge clk);
        end
        await_done(17, 16);
        chk("b2b_second_done", cyc - tf, 34);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
